// File: rtl/msg_rr_arbiter.sv
// rtl/msg_rr_arbiter.sv - round-robin merge of N_REQ sync/notify producers onto one held-message port
module msg_rr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 1,
    localparam int SRC_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_sync,
    output logic [N_REQ-1:0]        req_notify,
    output logic [DATA_W-1:0]       out_data,
    output logic [SRC_W-1:0]        out_src,
    output logic                    out_notify,
    input  logic                    out_sync
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_BURST - 1);
    localparam logic [SRC_W-1:0] LAST_INIT = SRC_W'(N_REQ - 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state;
    logic [SRC_W-1:0]  last;
    logic [CNT_W-1:0]  burst_cnt;
    logic [SRC_W-1:0]  winner;
    logic              burst_ok;
    logic              can_accept;
    logic              accept;

    // Burst keeps the previous winner; otherwise scan starts just after it.
    always_comb begin
        winner   = last;
        burst_ok = (MAX_BURST > 1) && req_sync[last] && (int'(burst_cnt) < MAX_BURST - 1);
        if (!burst_ok) begin
            for (int k = N_REQ; k >= 1; k--) begin
                if (req_sync[(int'(last) + k) % N_REQ])
                    winner = SRC_W'((int'(last) + k) % N_REQ);
            end
        end
    end

    assign can_accept = (state == EMPTY) | out_sync;
    assign accept     = can_accept & (|req_sync) & ~rst;
    assign req_notify = accept ? (N_REQ'(1) << winner) : '0;
    assign out_notify = (state == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_data  <= '0;
            out_src   <= '0;
            last      <= LAST_INIT;
            burst_cnt <= '0;
        end else if (accept) begin
            state    <= FULL;
            out_data <= req_data[winner*DATA_W +: DATA_W];
            out_src  <= winner;
            last     <= winner;
            if (winner != last)
                burst_cnt <= '0;
            else if (burst_cnt != CNT_MAX)
                burst_cnt <= burst_cnt + CNT_W'(1);
        end else if (state == FULL && out_sync) begin
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_msg_rr_arbiter.sv
// tb/tb_msg_rr_arbiter.sv - self-checking bench for msg_rr_arbiter with a behavioural reference model
module tb_msg_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] req_data;
    logic [3:0]   req_sync;
    logic [3:0]   req_notify;
    logic [31:0]  out_data;
    logic [1:0]   out_src;
    logic         out_notify;
    logic         out_sync;

    logic [127:0] req_data_b;
    logic [3:0]   req_sync_b;
    logic [3:0]   req_notify_b;
    logic [31:0]  out_data_b;
    logic [1:0]   out_src_b;
    logic         out_notify_b;
    logic         out_sync_b;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_last;
    bit          m_full;
    logic [31:0] m_data;
    int          m_src;

    always #5 clk = ~clk;

    msg_rr_arbiter #(.N_REQ(4), .DATA_W(32), .MAX_BURST(1)) dut (
        .clk(clk), .rst(rst), .req_data(req_data), .req_sync(req_sync),
        .req_notify(req_notify), .out_data(out_data), .out_src(out_src),
        .out_notify(out_notify), .out_sync(out_sync)
    );

    msg_rr_arbiter #(.N_REQ(4), .DATA_W(32), .MAX_BURST(3)) dut_b (
        .clk(clk), .rst(rst), .req_data(req_data_b), .req_sync(req_sync_b),
        .req_notify(req_notify_b), .out_data(out_data_b), .out_src(out_src_b),
        .out_notify(out_notify_b), .out_sync(out_sync_b)
    );

    // Reference: first active requester after the last winner, modulo 4.
    function automatic int m_pick(input logic [3:0] rs);
        for (int k = 1; k <= 4; k++)
            if (rs[(m_last + k) % 4]) return (m_last + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] m_notify(input logic [3:0] rs, input logic os);
        logic [3:0] one;
        int w;
        one = 4'b0001;
        w = m_pick(rs);
        if ((!m_full || os) && w >= 0) return one << w;
        return 4'b0000;
    endfunction

    function automatic void m_step();
        int w;
        w = m_pick(req_sync);
        if ((!m_full || out_sync) && w >= 0) begin
            m_full = 1'b1;
            m_data = req_data[w*32 +: 32];
            m_src  = w;
            m_last = w;
        end else if (m_full && out_sync) begin
            m_full = 1'b0;
        end
    endfunction

    function automatic void m_reset();
        m_last = 3;
        m_full = 1'b0;
        m_data = '0;
        m_src  = 0;
    endfunction

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_sync = '0; out_sync = 1'b0;
        req_sync_b = '0; out_sync_b = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_sync = 4'hF;
        req_data = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 4; c++) begin
            out_sync = 1'($urandom);
            @(negedge clk);
            n_tests++; if (req_notify !== 4'b0) begin n_fail++; $display("FAIL reset_req_notify c=%0d got=%b exp=0000", c, req_notify); end
            n_tests++; if (out_notify !== 1'b0) begin n_fail++; $display("FAIL reset_out_notify c=%0d got=%b exp=0", c, out_notify); end
            n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data c=%0d got=%h exp=0", c, out_data); end
            n_tests++; if (out_src !== 2'd0) begin n_fail++; $display("FAIL reset_out_src c=%0d got=%0d exp=0", c, out_src); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rn;
        do_reset();
        req_data = {32'h13, 32'h12, 32'h11, 32'h10};
        req_sync = 4'hF;
        out_sync = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            exp_rn = m_notify(req_sync, out_sync);
            n_tests++; if (req_notify !== exp_rn) begin n_fail++; $display("FAIL rr_req_notify c=%0d got=%b exp=%b", c, req_notify, exp_rn); end
            if (c > 0) begin
                n_tests++; if (out_notify !== 1'b1) begin n_fail++; $display("FAIL rr_bubble c=%0d got=%b exp=1", c, out_notify); end
                n_tests++; if (out_src !== 2'((c - 1) % 4)) begin n_fail++; $display("FAIL rr_src c=%0d got=%0d exp=%0d", c, out_src, (c - 1) % 4); end
                n_tests++; if (out_data !== 32'h10 + 32'((c - 1) % 4)) begin n_fail++; $display("FAIL rr_data c=%0d got=%h exp=%h", c, out_data, 32'h10 + 32'((c - 1) % 4)); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_data = '0;
        req_data[2*32 +: 32] = 32'h1234;
        req_data[3*32 +: 32] = 32'h3333;
        req_sync = 4'b1100;
        out_sync = 1'b0;
        @(negedge clk);
        n_tests++; if (req_notify !== 4'b0100) begin n_fail++; $display("FAIL bp_first_grant got=%b exp=0100", req_notify); end
        tick();
        req_sync = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++; if (out_notify !== 1'b1) begin n_fail++; $display("FAIL bp_notify c=%0d got=%b exp=1", c, out_notify); end
            n_tests++; if (out_data !== 32'h1234) begin n_fail++; $display("FAIL bp_data c=%0d got=%h exp=1234", c, out_data); end
            n_tests++; if (out_src !== 2'd2) begin n_fail++; $display("FAIL bp_src c=%0d got=%0d exp=2", c, out_src); end
            n_tests++; if (req_notify !== 4'b0000) begin n_fail++; $display("FAIL bp_req_notify c=%0d got=%b exp=0000", c, req_notify); end
            tick();
        end
        out_sync = 1'b1;
        @(negedge clk);
        n_tests++; if (req_notify !== 4'b1000) begin n_fail++; $display("FAIL bp_release_grant got=%b exp=1000", req_notify); end
        tick();
        req_sync = 4'b0000;
        @(negedge clk);
        n_tests++; if (out_notify !== 1'b1 || out_src !== 2'd3 || out_data !== 32'h3333) begin
            n_fail++; $display("FAIL bp_next_msg got=%b/%0d/%h exp=1/3/3333", out_notify, out_src, out_data);
        end
        tick();
    endtask

    task automatic test_burst();
        int         exp_seq[9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        logic [3:0] one;
        one = 4'b0001;
        do_reset();
        req_data_b = {$urandom, $urandom, $urandom, $urandom};
        req_sync_b = 4'b0011;
        out_sync_b = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            n_tests++; if (req_notify_b !== (one << exp_seq[c])) begin n_fail++; $display("FAIL burst_seq c=%0d got=%b exp=%b", c, req_notify_b, one << exp_seq[c]); end
            @(posedge clk);
            #1;
        end
        do_reset();
        req_sync_b = 4'b0011;
        out_sync_b = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        req_sync_b = 4'b0010;
        @(negedge clk);
        n_tests++; if (req_notify_b !== 4'b0010) begin n_fail++; $display("FAIL burst_drop got=%b exp=0010", req_notify_b); end
        @(posedge clk);
        #1;
        req_sync_b = 4'b0000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_data = '0;
        req_data[3*32 +: 32] = 32'h55;
        req_sync = 4'b1000;
        out_sync = 1'b0;
        @(negedge clk);
        n_tests++; if (req_notify !== 4'b1000) begin n_fail++; $display("FAIL rm_grant3 got=%b exp=1000", req_notify); end
        tick();
        req_sync = 4'b0000;
        @(negedge clk);
        n_tests++; if (out_notify !== 1'b1 || out_data !== 32'h55) begin n_fail++; $display("FAIL rm_held got=%b/%h exp=1/55", out_notify, out_data); end
        #1;
        rst = 1'b1;
        #1;
        n_tests++; if (out_notify !== 1'b0) begin n_fail++; $display("FAIL rm_async_drop got=%b exp=0", out_notify); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        req_data[1*32 +: 32] = 32'h11;
        req_data[3*32 +: 32] = 32'h56;
        req_sync = 4'b1010;
        out_sync = 1'b1;
        @(negedge clk);
        n_tests++; if (req_notify !== 4'b0010) begin n_fail++; $display("FAIL rm_first_after got=%b exp=0010", req_notify); end
        tick();
        @(negedge clk);
        n_tests++; if (out_src !== 2'd1 || out_data !== 32'h11) begin n_fail++; $display("FAIL rm_deliver got=%0d/%h exp=1/11", out_src, out_data); end
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            n_tests++; if (out_notify && out_data === 32'h55) begin n_fail++; $display("FAIL rm_stale c=%0d got=%h exp=not 55", c, out_data); end
        end
        tick();
        req_sync = 4'b0000;
    endtask

    task automatic test_sparse();
        do_reset();
        req_data = '0;
        out_sync = 1'b1;
        for (int m = 0; m < 4; m++) begin
            req_sync = 4'b1000;
            req_data[3*32 +: 32] = 32'h300 + 32'(m);
            @(negedge clk);
            n_tests++; if (req_notify !== 4'b1000) begin n_fail++; $display("FAIL sp_accept m=%0d got=%b exp=1000", m, req_notify); end
            tick();
            req_sync = 4'b0000;
            @(negedge clk);
            n_tests++; if (out_notify !== 1'b1 || out_src !== 2'd3 || out_data !== 32'h300 + 32'(m)) begin
                n_fail++; $display("FAIL sp_deliver m=%0d got=%b/%0d/%h exp=1/3/%h", m, out_notify, out_src, out_data, 32'h300 + 32'(m));
            end
            tick();
            @(negedge clk);
            n_tests++; if (out_notify !== 1'b0 || req_notify !== 4'b0000) begin n_fail++; $display("FAIL sp_idle m=%0d got=%b/%b exp=0/0000", m, out_notify, req_notify); end
            tick();
            tick();
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_rn;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_sync = 4'($urandom);
            req_data = {$urandom, $urandom, $urandom, $urandom};
            out_sync = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_rn = m_notify(req_sync, out_sync);
            n_tests++; if (req_notify !== exp_rn) begin n_fail++; $display("FAIL rnd_req_notify c=%0d got=%b exp=%b", c, req_notify, exp_rn); end
            n_tests++; if (out_notify !== m_full) begin n_fail++; $display("FAIL rnd_out_notify c=%0d got=%b exp=%b", c, out_notify, m_full); end
            if (m_full) begin
                n_tests++; if (out_data !== m_data || out_src !== 2'(m_src)) begin
                    n_fail++; $display("FAIL rnd_msg c=%0d got=%0d/%h exp=%0d/%h", c, out_src, out_data, m_src, m_data);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        req_data = '0; req_sync = '0; out_sync = 1'b0;
        req_data_b = '0; req_sync_b = '0; out_sync_b = 1'b0;
        m_reset();
        #1;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_burst();
        test_reset_mid();
        test_sparse();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
